// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU blocks.
// Holds the default datapath width and the sequencer state type.
package alu_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle of the bit-serial subtractor.
// The master side issues operands and start; the slave returns results.
interface serial_subtractor_if
  import alu_pkg::*;
#(
  parameter int width = WIDTH
);

  logic             start;
  logic [width-1:0] A;
  logic [width-1:0] B;
  logic             Bin;
  logic             busy;
  logic             done;
  logic [width-1:0] out;
  logic             Bout;
  logic             overflow;
  logic             zero;
  logic             negative;

  modport master (
    output start, A, B, Bin,
    input  busy, done, out, Bout,
    input  overflow, zero, negative
  );

  modport slave (
    input  start, A, B, Bin,
    output busy, done, out, Bout,
    output overflow, zero, negative
  );

endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: diff = a - b - bin.
// bout is the borrow passed to the next more significant bit.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one bit per clock, LSB first.
// Result and flags are registered when the last bit completes.
module serial_subtractor
  import alu_pkg::*;
#(
  parameter int width = WIDTH
) (
  input  logic            clk,
  input  logic            reset_n,
  serial_subtractor_if.slave io
);

  localparam int CW = $clog2(width);
  localparam logic [CW-1:0] LAST = CW'(width - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [width-1:0] a_q, a_d;
  logic [width-1:0] b_q, b_d;
  logic             brw_q, brw_d;
  logic [width-2:0] acc_q, acc_d;
  logic [width-1:0] out_q, out_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;

  logic             diff;
  logic             bout;
  logic [width-1:0] res;
  logic             cap;

  full_subtractor u_fs (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (brw_q),
    .diff (diff),
    .bout (bout)
  );

  // New bit enters at the top; after width steps res is the full result.
  assign res = {diff, acc_q};
  assign cap = io.start && (state_q != RUN);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    brw_d   = brw_q;
    acc_d   = acc_q;
    out_d   = out_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    unique case (state_q)
      IDLE: ;
      DONE: state_d = IDLE;
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        brw_d = bout;
        acc_d = res[width-1:1];
        if (cnt_q == LAST) begin
          state_d = DONE;
          out_d   = res;
          bout_d  = bout;
          ovf_d   = (a_q[0] ^ b_q[0]) & (diff ^ a_q[0]);
          zero_d  = (res == '0);
          neg_d   = diff;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (cap) begin
      state_d = RUN;
      cnt_d   = '0;
      a_d     = io.A;
      b_d     = io.B;
      brw_d   = io.Bin;
      acc_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      brw_q   <= 1'b0;
      acc_q   <= '0;
      out_q   <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b1;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      brw_q   <= brw_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
    end
  end

  assign io.busy     = (state_q == RUN);
  assign io.done     = (state_q == DONE);
  assign io.out      = out_q;
  assign io.Bout     = bout_q;
  assign io.overflow = ovf_q;
  assign io.zero     = zero_q;
  assign io.negative = neg_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor.
// Directed table, corner sequences, strided sweep and random operands.
module tb_serial_subtractor;

  localparam int W = 32;

  logic clk;
  logic reset_n;
  int   n_vec;
  int   n_bad;

  serial_subtractor_if #(.width(W)) io ();

  serial_subtractor #(.width(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .io      (io.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] eout;
    logic         ebout;
    logic         eovf;
    logic         ezero;
    logic         eneg;
  } vec_t;

  typedef struct {
    logic [W-1:0] out;
    logic         bout;
    logic         ovf;
    logic         zero;
    logic         neg;
  } res_t;

  vec_t tbl [8];

  function automatic res_t model(input logic [W-1:0] a,
                                 input logic [W-1:0] b,
                                 input logic bi);
    res_t r;
    logic [W:0] d;
    d      = {1'b0, a} - {1'b0, b} - (W+1)'(bi);
    r.out  = d[W-1:0];
    r.bout = d[W];
    r.ovf  = (a[W-1] != b[W-1]) && (r.out[W-1] != a[W-1]);
    r.zero = (r.out == '0);
    r.neg  = r.out[W-1];
    return r;
  endfunction

  task automatic chk(input string name,
                     input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input res_t e);
    chk({tag, ".out"}, io.out, e.out);
    chk({tag, ".Bout"}, W'(io.Bout), W'(e.bout));
    chk({tag, ".ovf"}, W'(io.overflow), W'(e.ovf));
    chk({tag, ".zero"}, W'(io.zero), W'(e.zero));
    chk({tag, ".neg"}, W'(io.negative), W'(e.neg));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".busy"}, W'(io.busy), '0);
    chk({tag, ".done"}, W'(io.done), '0);
    chk({tag, ".out"}, io.out, '0);
    chk({tag, ".Bout"}, W'(io.Bout), '0);
    chk({tag, ".ovf"}, W'(io.overflow), '0);
    chk({tag, ".zero"}, W'(io.zero), W'(1));
    chk({tag, ".neg"}, W'(io.negative), '0);
  endtask

  // Operands are scrambled after capture; they must not matter.
  task automatic start_op(input logic [W-1:0] a,
                          input logic [W-1:0] b,
                          input logic bi);
    @(negedge clk);
    io.A     = a;
    io.B     = b;
    io.Bin   = bi;
    io.start = 1'b1;
    @(posedge clk);
    #1;
    io.start = 1'b0;
    io.A     = $urandom;
    io.B     = $urandom;
    io.Bin   = 1'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (lat < W + 8) begin
      @(posedge clk);
      #1;
      lat++;
      if (io.done) break;
    end
  endtask

  task automatic run_chk(input string tag,
                         input logic [W-1:0] a,
                         input logic [W-1:0] b,
                         input logic bi);
    int lat;
    start_op(a, b, bi);
    wait_done(lat);
    chk({tag, ".lat"}, W'(lat), W'(W));
    chk_out(tag, model(a, b, bi));
    chk({tag, ".sum"}, io.out + b + W'(bi), a);
  endtask

  initial begin
    int lat;
    int ndone;
    res_t e;
    logic [W-1:0] a;
    logic [W-1:0] b;
    n_vec    = 0;
    n_bad    = 0;
    io.start = 1'b0;
    io.A     = '0;
    io.B     = '0;
    io.Bin   = 1'b0;

    tbl[0] = '{32'd5, 32'd3, 1'b0, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{32'd0, 32'd1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{32'h80000000, 32'd1, 1'b0, 32'h7FFFFFFF,
               1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{32'hFFFFFFFE, 32'h4, 1'b1, 32'hFFFFFFF9,
               1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{32'h12345678, 32'h12345678, 1'b0, 32'h0,
               1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{32'd0, 32'd0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000,
               1'b1, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF,
               1'b1, 1'b0, 1'b0, 1'b1};

    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      start_op(tbl[i].a, tbl[i].b, tbl[i].bin);
      chk($sformatf("tbl%0d.busy", i), W'(io.busy), W'(1));
      wait_done(lat);
      chk($sformatf("tbl%0d.lat", i), W'(lat), W'(W));
      chk($sformatf("tbl%0d.out", i), io.out, tbl[i].eout);
      chk($sformatf("tbl%0d.Bout", i), W'(io.Bout), W'(tbl[i].ebout));
      chk($sformatf("tbl%0d.ovf", i), W'(io.overflow), W'(tbl[i].eovf));
      chk($sformatf("tbl%0d.zero", i), W'(io.zero), W'(tbl[i].ezero));
      chk($sformatf("tbl%0d.neg", i), W'(io.negative), W'(tbl[i].eneg));
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d.pulse", i), W'(io.done), '0);
      chk($sformatf("tbl%0d.hold", i), io.out, tbl[i].eout);
    end

    // start pulsed on RUN cycle 10 must not disturb the running op
    start_op(32'd1000, 32'd1, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    io.A     = 32'hDEADBEEF;
    io.B     = 32'h1;
    io.Bin   = 1'b1;
    io.start = 1'b1;
    @(posedge clk);
    #1;
    io.start = 1'b0;
    wait_done(lat);
    chk("ign.lat", W'(lat + 10), W'(W));
    chk_out("ign", model(32'd1000, 32'd1, 1'b0));

    // start held in DONE: straight back into RUN
    start_op(32'h00000010, 32'h00000020, 1'b1);
    chk("b2b.busy", W'(io.busy), W'(1));
    chk("b2b.nodone", W'(io.done), '0);
    wait_done(lat);
    chk("b2b.lat", W'(lat), W'(W));
    chk_out("b2b", model(32'h10, 32'h20, 1'b1));

    // reset mid-RUN abandons the op
    start_op(32'hCAFEF00D, 32'h00000123, 1'b0);
    repeat (15) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(negedge clk);
    reset_n = 1'b1;
    ndone = 0;
    repeat (W + 8) begin
      @(posedge clk);
      #1;
      if (io.done) ndone++;
    end
    chk("midrst.nodone", W'(ndone), '0);
    chk("midrst.out", io.out, '0);
    run_chk("postrst", 32'h00000009, 32'h00000004, 1'b1);

    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++) begin
        for (int k = 0; k < 2; k++) begin
          a = W'(i) * 32'h3FFFFFFF + W'(i);
          b = W'(j) * 32'h3C3C3C3D;
          run_chk($sformatf("sw%0d_%0d_%0d", i, j, k), a, b, k[0]);
        end
      end
    end

    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      b = (i % 5 == 0) ? a : $urandom;
      run_chk($sformatf("rnd%0d", i), a, b, 1'($urandom));
      if ($urandom_range(0, 1) == 1) repeat (2) @(posedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter width, default 32, meaning operand and result width in bits (width >= 2).
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 The block SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port start  input  1  request to capture operands and begin a subtraction.
REQ-005 The block SHALL have port A  input  width  minuend, sampled only on an accepted start.
REQ-006 The block SHALL have port B  input  width  subtrahend, sampled only on an accepted start.
REQ-007 The block SHALL have port Bin  input  1  borrow-in, sampled only on an accepted start.
REQ-008 The block SHALL have port busy  output  1  high while an operation is in progress (state RUN).
REQ-009 The block SHALL have port done  output  1  one-cycle pulse marking valid results.
REQ-010 The block SHALL have port out  output  width  result A - B - Bin, modulo 2^width.
REQ-011 The block SHALL have port Bout  output  1  unsigned borrow-out: 1 iff A < B + Bin as unsigned integers.
REQ-012 The block SHALL have port overflow  output  1  signed overflow: A[msb] != B[msb] and out[msb] != A[msb].
REQ-013 The block SHALL have ports zero and negative  output  1 each  out == 0 and out[msb], respectively.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 IDLE: start=1 at a rising edge SHALL capture A, B and Bin, clear the bit counter to 0 and enter RUN.
REQ-016 RUN: each rising edge SHALL process one bit, LSB first, producing diff = a^b^borrow and borrow' = (~a&b)|(~(a^b)&borrow).
REQ-017 The initial borrow SHALL equal the captured Bin.
REQ-018 RUN SHALL last exactly width rising edges; on the width-th edge the state SHALL become DONE.
REQ-019 done SHALL be high for exactly one cycle, width cycles after the capture edge; total latency is start-capture edge + width.
REQ-020 out, Bout, overflow, zero and negative SHALL update only on the edge entering DONE and SHALL hold until the next completion.
REQ-021 DONE: with start=0 the next state SHALL be IDLE; with start=1 the block SHALL capture new operands and go straight to RUN (back-to-back operation).
REQ-022 start SHALL be ignored while in RUN; captured operands SHALL remain unchanged during RUN.
REQ-023 A, B and Bin changes outside an accepted start SHALL have no effect.
REQ-024 The bit counter SHALL be ceil(log2(width)) bits wide and SHALL NOT wrap within an operation.

Reset
REQ-025 reset_n=0 SHALL immediately force state IDLE and clear the counter, captured operands and borrow, regardless of clock.
REQ-026 During and after reset: busy=0, done=0, out=0, Bout=0, overflow=0, zero=1, negative=0.
REQ-027 Reset asserted mid-RUN SHALL abandon the operation with no done pulse; the first start after release SHALL behave as from power-up.

Structure
REQ-028 A shared package alu_pkg SHALL hold the default WIDTH constant and the state enum type (IDLE, RUN, DONE).
REQ-029 The 1-bit full-subtractor cell SHALL be a separate sub-module full_subtractor (ports a, b, bin, diff, bout), instantiated once.

Verification
REQ-030 Reset: hold reset_n=0 two cycles -> busy=0, done=0, out=0, zero=1, all other flags 0.
REQ-031 A=5, B=3, Bin=0 -> done exactly 32 cycles after capture; out=2, Bout=0, overflow=0, zero=0, negative=0.
REQ-032 A=0, B=1, Bin=0 -> out=32'hFFFFFFFF, Bout=1, negative=1, overflow=0; A=32'h80000000, B=1 -> out=32'h7FFFFFFF, overflow=1, Bout=0.
REQ-033 A=32'hFFFFFFFE, B=32'h4, Bin=1 -> out=32'hFFFFFFF9, Bout=0, negative=1; A=B=32'h12345678, Bin=0 -> out=0, zero=1.
REQ-034 start pulsed at RUN cycle 10 with different operands -> ignored, original result delivered; start held in DONE -> next done exactly 32 cycles later with new result.
REQ-035 reset_n pulsed low at RUN cycle 16 -> no done, outputs at reset values; plus sweep of A, B (strided ranges, both Bin) checking out + B + Bin == A mod 2^32.
